// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multi-cycle sequencer for the RV32I shared datapath (one memory port,
//   one ALU, register file, immediate generator). Walks each instruction
//   through FETCH/DECODE/EXEC/MEM/WB and handshakes with the memory port.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   instr[31:0]       instruction register contents (valid from DECODE)
//   branch_taken      ALU comparison result, valid in EXEC
//   mem_ready         memory completes the current request this cycle
//   mem_req/mem_we    memory request / store
//   mem_addr_sel      0 = PC, 1 = ALU result
//   ir_write          load IR (and latch old PC)
//   pc_write/pc_src   PC update / 0 = PC+4, 1 = PC+imm
//   reg_write/wb_sel  register write enable / 00 ALU, 01 mem, 10 PC+4
//   alu_src_b/alu_op  0 = rs2, 1 = imm / 00 add, 01 compare, 10 funct decode
//   instr_retired     one-cycle pulse per completed instruction
//   illegal           sticky: unsupported opcode
//   bus_error         sticky: memory timeout
//   state[2:0]        current state (debug)

module multicycle_control_unit #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        instr_retired,
  output logic        illegal,
  output logic        bus_error,
  output logic [2:0]  state
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);
  // Last cycle a request may stay unanswered; the miss on this count times out.
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LIMIT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  function automatic logic is_supported(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL: is_supported = 1'b1;
      default:                                      is_supported = 1'b0;
    endcase
  endfunction

  // Kept as plain bits so the unused codes 6 and 7 remain representable.
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          illegal_q, bus_error_q;

  logic [6:0] opcode_s;
  logic       rd_zero_s;
  logic       set_illegal_s, timeout_s;
  logic       mem_req_s, mem_we_s, mem_addr_sel_s, ir_write_s;
  logic       pc_write_s, pc_src_s, reg_write_raw_s, alu_src_b_s, retired_s;
  logic [1:0] wb_sel_s, alu_op_s;
  logic       instr_unused_s;

  assign opcode_s       = instr[6:0];
  assign rd_zero_s      = (instr[11:7] == 5'd0);
  assign instr_unused_s = ^instr[31:12];

  // Next-state and strobe decode for the current state.
  always_comb begin
    state_d         = state_q;
    set_illegal_s   = 1'b0;
    timeout_s       = 1'b0;
    mem_req_s       = 1'b0;
    mem_we_s        = 1'b0;
    mem_addr_sel_s  = 1'b0;
    ir_write_s      = 1'b0;
    pc_write_s      = 1'b0;
    pc_src_s        = 1'b0;
    reg_write_raw_s = 1'b0;
    wb_sel_s        = 2'b00;
    alu_src_b_s     = 1'b0;
    alu_op_s        = 2'b00;
    retired_s       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_s = 1'b1;
        if (mem_ready) begin
          ir_write_s = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          timeout_s = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (is_supported(opcode_s)) begin
          state_d = S_EXEC;
        end else begin
          set_illegal_s = 1'b1;
          state_d       = S_HALT;
        end
      end
      S_EXEC: begin
        case (opcode_s)
          OP_R: begin
            alu_op_s = 2'b10;
            state_d  = S_WB;
          end
          OP_I: begin
            alu_op_s    = 2'b10;
            alu_src_b_s = 1'b1;
            state_d     = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b_s = 1'b1;
            state_d     = S_MEM;
          end
          OP_BR: begin
            alu_op_s   = 2'b01;
            pc_write_s = 1'b1;
            pc_src_s   = branch_taken;
            retired_s  = 1'b1;
            state_d    = S_FETCH;
          end
          OP_JAL: begin
            // Link value comes from the PC latched alongside the IR.
            reg_write_raw_s = 1'b1;
            wb_sel_s        = 2'b10;
            pc_write_s      = 1'b1;
            pc_src_s        = 1'b1;
            retired_s       = 1'b1;
            state_d         = S_FETCH;
          end
          default: begin
            // IR changed under us after DECODE: treat as illegal.
            set_illegal_s = 1'b1;
            state_d       = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        mem_req_s      = 1'b1;
        mem_addr_sel_s = 1'b1;
        mem_we_s       = (opcode_s == OP_STORE);
        if (mem_ready) begin
          if (opcode_s == OP_STORE) begin
            pc_write_s = 1'b1;
            retired_s  = 1'b1;
            state_d    = S_FETCH;
          end else if (opcode_s == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            set_illegal_s = 1'b1;
            state_d       = S_HALT;
          end
        end else if (wait_q == WAIT_LAST) begin
          timeout_s = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        reg_write_raw_s = 1'b1;
        wb_sel_s        = (opcode_s == OP_LOAD) ? 2'b01 : 2'b00;
        pc_write_s      = 1'b1;
        retired_s       = 1'b1;
        state_d         = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // Wait counter: clears on any state change or completion, counts missed requests.
  always_comb begin
    if ((state_d != state_q) || mem_ready) begin
      wait_d = '0;
    end else if ((state_q == S_FETCH) || (state_q == S_MEM)) begin
      wait_d = wait_q + CW'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  // State, wait counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      wait_q      <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (set_illegal_s) begin
        illegal_q <= 1'b1;
      end
      if (timeout_s) begin
        bus_error_q <= 1'b1;
      end
    end
  end

  // Strobes are qualified by rst_n so an in-flight request drops the moment
  // reset asserts instead of presenting a FETCH request during reset.
  assign mem_req       = mem_req_s & rst_n;
  assign mem_we        = mem_we_s & rst_n;
  assign mem_addr_sel  = mem_addr_sel_s & rst_n;
  assign ir_write      = ir_write_s & rst_n;
  assign pc_write      = pc_write_s & rst_n;
  assign pc_src        = pc_src_s & rst_n;
  assign reg_write     = reg_write_raw_s & ~rd_zero_s & rst_n;
  assign wb_sel        = wb_sel_s & {2{rst_n}};
  assign alu_src_b     = alu_src_b_s & rst_n;
  assign alu_op        = alu_op_s & {2{rst_n}};
  assign instr_retired = retired_s & rst_n;
  assign illegal       = illegal_q;
  assign bus_error     = bus_error_q;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit. Stimulus drives one cycle at
// a time and queues the hand-computed output vector for that cycle; the
// monitor pops and compares on the falling edge.

module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        branch_taken, mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
  logic        reg_write, alu_src_b, instr_retired, illegal, bus_error;
  logic [1:0]  wb_sel, alu_op;
  logic [2:0]  state;

  always #5 clk = ~clk;

  multicycle_control_unit #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_retired(instr_retired),
    .illegal(illegal), .bus_error(bus_error), .state(state)
  );

  localparam logic [31:0] ADDI  = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] LW    = 32'h0000_A103; // lw x2,0(x1)
  localparam logic [31:0] SW    = 32'h0020_A023; // sw x2,0(x1)
  localparam logic [31:0] BEQ   = 32'h0000_0463;
  localparam logic [31:0] JAL1  = 32'h0080_00EF; // jal x1,8
  localparam logic [31:0] JAL0  = 32'h0080_006F; // jal x0,8
  localparam logic [31:0] ILLOP = 32'h0000_007F;

  // Vector layout: {state, req, we, asel, irw, pcw, pcs, rw, wb_sel, alu_src_b, alu_op, retired, illegal, bus_error}
  function automatic logic [17:0] ev(input logic [2:0] st, input logic [6:0] strb,
                                     input logic [1:0] wbs, input logic asb,
                                     input logic [1:0] aop, input logic ret,
                                     input logic ill, input logic berr);
    ev = {st, strb, wbs, asb, aop, ret, ill, berr};
  endfunction

  logic [17:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [17:0] act_s, mon_e;
  string       mon_t;

  assign act_s = {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                  reg_write, wb_sel, alu_src_b, alu_op, instr_retired, illegal, bus_error};

  // Monitor: one queued expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      n_checks++;
      if (act_s !== mon_e) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", mon_t, act_s, mon_e);
      end
    end
  end

  task automatic step(input logic [31:0] ins, input logic rdy, input logic bt,
                      input logic [17:0] e, input string tag);
    instr        = ins;
    mem_ready    = rdy;
    branch_taken = bt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; instr = 32'h0; mem_ready = 1'b0; branch_taken = 1'b0;
    @(posedge clk); #1;
    step(ADDI, 1'b1, 1'b0, ev(3'd0, 7'b0000000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "reset");
    rst_n = 1'b1;

    // addi x1,x0,5 zero-wait; mem_ready in DECODE/WB must be ignored
    step(ADDI, 1'b1, 1'b0, ev(3'd0, 7'b1001000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "addi_fetch");
    step(ADDI, 1'b1, 1'b0, ev(3'd1, 7'b0000000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "addi_decode");
    step(ADDI, 1'b0, 1'b0, ev(3'd2, 7'b0000000, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0), "addi_exec");
    step(ADDI, 1'b1, 1'b0, ev(3'd4, 7'b0000101, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0), "addi_wb");

    // lw x2,0(x1) with two wait states per access: 9 cycles
    step(LW, 1'b0, 1'b0, ev(3'd0, 7'b1000000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "lw_fetch_w1");
    step(LW, 1'b0, 1'b0, ev(3'd0, 7'b1000000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "lw_fetch_w2");
    step(LW, 1'b1, 1'b0, ev(3'd0, 7'b1001000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "lw_fetch_done");
    step(LW, 1'b0, 1'b0, ev(3'd1, 7'b0000000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "lw_decode");
    step(LW, 1'b0, 1'b0, ev(3'd2, 7'b0000000, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0), "lw_exec");
    step(LW, 1'b0, 1'b0, ev(3'd3, 7'b1010000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "lw_mem_w1");
    step(LW, 1'b0, 1'b0, ev(3'd3, 7'b1010000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "lw_mem_w2");
    step(LW, 1'b1, 1'b0, ev(3'd3, 7'b1010000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "lw_mem_done");
    step(LW, 1'b0, 1'b0, ev(3'd4, 7'b0000101, 2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0), "lw_wb");

    // sw zero-wait: retires in MEM, 4 cycles
    step(SW, 1'b1, 1'b0, ev(3'd0, 7'b1001000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "sw_fetch");
    step(SW, 1'b0, 1'b0, ev(3'd1, 7'b0000000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "sw_decode");
    step(SW, 1'b0, 1'b0, ev(3'd2, 7'b0000000, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0), "sw_exec");
    step(SW, 1'b1, 1'b0, ev(3'd3, 7'b1110100, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0), "sw_mem");

    // beq taken then not taken, 3 cycles each
    for (int k = 0; k < 2; k++) begin
      logic bt_l;
      bt_l = (k == 0) ? 1'b1 : 1'b0;
      step(BEQ, 1'b1, 1'b0, ev(3'd0, 7'b1001000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "beq_fetch");
      step(BEQ, 1'b0, 1'b0, ev(3'd1, 7'b0000000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "beq_decode");
      step(BEQ, 1'b0, bt_l, ev(3'd2, {4'b0000, 1'b1, bt_l, 1'b0}, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0),
           (k == 0) ? "beq_exec_taken" : "beq_exec_not_taken");
    end

    // jal x1,8 links; jal x0,8 must not write the register file
    step(JAL1, 1'b1, 1'b0, ev(3'd0, 7'b1001000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "jal1_fetch");
    step(JAL1, 1'b0, 1'b0, ev(3'd1, 7'b0000000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "jal1_decode");
    step(JAL1, 1'b0, 1'b0, ev(3'd2, 7'b0000111, 2'b10, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0), "jal1_exec");
    step(JAL0, 1'b1, 1'b0, ev(3'd0, 7'b1001000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "jal0_fetch");
    step(JAL0, 1'b0, 1'b0, ev(3'd1, 7'b0000000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "jal0_decode");
    step(JAL0, 1'b0, 1'b0, ev(3'd2, 7'b0000110, 2'b10, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0), "jal0_exec");

    // Reset during a store's MEM wait: strobes drop at once, no pc_write
    step(SW, 1'b1, 1'b0, ev(3'd0, 7'b1001000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "swr_fetch");
    step(SW, 1'b0, 1'b0, ev(3'd1, 7'b0000000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "swr_decode");
    step(SW, 1'b0, 1'b0, ev(3'd2, 7'b0000000, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0), "swr_exec");
    step(SW, 1'b0, 1'b0, ev(3'd3, 7'b1110000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "swr_mem_wait");
    rst_n = 1'b0;
    step(SW, 1'b1, 1'b0, ev(3'd0, 7'b0000000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "swr_in_reset");
    rst_n = 1'b1;

    // Illegal opcode: sticky flag, HALT with no requests, reset recovers
    step(ILLOP, 1'b1, 1'b0, ev(3'd0, 7'b1001000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "ill_fetch");
    step(ILLOP, 1'b0, 1'b0, ev(3'd1, 7'b0000000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "ill_decode");
    for (int k = 0; k < 20; k++) begin
      step(ILLOP, k[0], 1'b0, ev(3'd5, 7'b0000000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0), "ill_halt");
    end
    rst_n = 1'b0;
    step(ADDI, 1'b0, 1'b0, ev(3'd0, 7'b0000000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "ill_in_reset");
    rst_n = 1'b1;

    // Timeout: four unanswered FETCH requests, then HALT with bus_error
    for (int k = 0; k < 4; k++) begin
      step(ADDI, 1'b0, 1'b0, ev(3'd0, 7'b1000000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), "to_fetch");
    end
    for (int k = 0; k < 3; k++) begin
      step(ADDI, 1'b1, 1'b0, ev(3'd5, 7'b0000000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1), "to_halt");
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
